// File: rtl/input_conditioner.sv
// Raw button/switch front-end: 2-FF synchroniser, polarity normalisation, tick-based debounce, press/release strobes.
// Optional latching toggle output enabled by defining INPUT_CONDITIONER_TOGGLE_EN.
module input_conditioner #(
  parameter int WIDTH        = 4,
  parameter int OUT_W        = 32,
  parameter int TICK_CYCLES  = 50000,
  parameter int STABLE_TICKS = 10,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [OUT_W-1:0] level_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             tick_out
`ifdef INPUT_CONDITIONER_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] toggle_state
`endif
);

  localparam int               PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [WIDTH-1:0] INACTIVE = {WIDTH{ACTIVE_LOW}};
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [3:0]       CNT_LAST = 4'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] norm_s;
  logic [PW-1:0]    pre_cnt_r;
  logic             tick_s;
  logic [WIDTH-1:0] stable_r;
  logic [3:0]       cnt_r      [WIDTH];
  logic [3:0]       cnt_next_s [WIDTH];
  logic [WIDTH-1:0] stable_next_s;
  logic [WIDTH-1:0] press_next_s;
  logic [WIDTH-1:0] release_next_s;

  // Two-stage synchroniser; resets to the idle raw level so no phantom edge follows reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_r <= INACTIVE;
      sync2_r <= INACTIVE;
    end else begin
      sync1_r <= raw_in;
      sync2_r <= sync1_r;
    end
  end

  assign norm_s = sync2_r ^ INACTIVE;
  assign tick_s = (pre_cnt_r == PRE_LAST);

  // Shared prescaler producing one tick every TICK_CYCLES clocks.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pre_cnt_r <= '0;
      tick_out  <= 1'b0;
    end else begin
      if (tick_s) begin
        pre_cnt_r <= '0;
      end else begin
        pre_cnt_r <= pre_cnt_r + PW'(1);
      end
      tick_out <= tick_s;
    end
  end

  // Per-bit qualification: a differing value must survive STABLE_TICKS ticks without bouncing back.
  always_comb begin
    cnt_next_s     = cnt_r;
    stable_next_s  = stable_r;
    press_next_s   = '0;
    release_next_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (norm_s[i] == stable_r[i]) begin
        cnt_next_s[i] = 4'd0;
      end else if (tick_s && (cnt_r[i] == CNT_LAST)) begin
        cnt_next_s[i]     = 4'd0;
        stable_next_s[i]  = norm_s[i];
        press_next_s[i]   = norm_s[i];
        release_next_s[i] = ~norm_s[i];
      end else if (tick_s) begin
        cnt_next_s[i] = cnt_r[i] + 4'd1;
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
  end

  // Debounce state, counters and edge strobes.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_r      <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= 4'd0;
      end
    end else begin
      stable_r      <= stable_next_s;
      press_pulse   <= press_next_s;
      release_pulse <= release_next_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

  // Zero-extend the debounced level to the PIO width.
  always_comb begin
    level_out              = '0;
    level_out[WIDTH-1:0]   = stable_r;
  end

`ifdef INPUT_CONDITIONER_TOGGLE_EN
  // Latching toggle flips on each accepted press.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      toggle_state <= '0;
    end else begin
      toggle_state <= toggle_state ^ press_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (WIDTH=4, TICK_CYCLES=4, STABLE_TICKS=3, ACTIVE_LOW=1).
module tb_input_conditioner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  raw;
  logic [31:0] level;
  logic [3:0]  press;
  logic [3:0]  rel;
  logic        tick;
`ifdef INPUT_CONDITIONER_TOGGLE_EN
  logic [3:0]  toggle;
`endif

  int tests = 0;
  int fails = 0;

  input_conditioner #(
    .WIDTH(4), .OUT_W(32), .TICK_CYCLES(4), .STABLE_TICKS(3), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .raw_in(raw),
    .level_out(level),
    .press_pulse(press),
    .release_pulse(rel),
    .tick_out(tick)
`ifdef INPUT_CONDITIONER_TOGGLE_EN
    ,
    .toggle_state(toggle)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int nc);
    repeat (nc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Watch a 20-cycle window for a pulse; report first cycle, pulse count, and values at that cycle.
  task automatic wait_pulse(input bit want_rel, output int k, output int n,
                            output logic [3:0] pv, output logic [31:0] lv);
    logic [3:0] p;
    k = 0; n = 0; pv = 4'h0; lv = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      cyc(1);
      p = want_rel ? rel : press;
      if (p != 4'h0) begin
        n++;
        if (k == 0) begin
          k  = c;
          pv = p;
          lv = level;
        end
      end
    end
  endtask

  initial begin
    int k, n, bad, nticks, last, gap_bad;
    logic [3:0]  pv;
    logic [31:0] lv;

    // Reset with keys released
    rst_n = 1'b0;
    raw   = 4'hF;
    cyc(3);
    check("rst_level", level, 32'h0);
    check("rst_press", {28'h0, press}, 32'h0);
    check("rst_release", {28'h0, rel}, 32'h0);
    check("rst_tick", {31'h0, tick}, 32'h0);
    rst_n = 1'b1;
    bad = 0; nticks = 0; last = 0; gap_bad = 0;
    for (int c = 1; c <= 100; c++) begin
      cyc(1);
      if (press != 4'h0 || rel != 4'h0 || level != 32'h0) bad++;
      if (tick) begin
        nticks++;
        if (c - last != 4) gap_bad++;
        last = c;
      end
    end
    check("idle_no_activity", bad, 0);
    check("idle_tick_count", nticks, 25);
    check("idle_tick_spacing", gap_bad, 0);

    // Clean press and release of bit0
    raw = 4'hE;
    wait_pulse(1'b0, k, n, pv, lv);
    check("press_latency_in_range", {31'h0, (k >= 11 && k <= 14)}, 32'h1);
    check("press_value", {28'h0, pv}, 32'h1);
    check("press_level", lv, 32'h1);
    check("press_single", n, 1);
    check("press_level_hold", level, 32'h1);
    raw = 4'hF;
    wait_pulse(1'b1, k, n, pv, lv);
    check("release_latency_in_range", {31'h0, (k >= 11 && k <= 14)}, 32'h1);
    check("release_value", {28'h0, pv}, 32'h1);
    check("release_level", lv, 32'h0);
    check("release_single", n, 1);

    // Bounce on bit0: 3-cycle phases can never span 3 ticks
    bad = 0;
    for (int ph = 0; ph < 20; ph++) begin
      raw = (ph % 2 == 0) ? 4'hE : 4'hF;
      for (int c = 0; c < 3; c++) begin
        cyc(1);
        if (press != 4'h0 || rel != 4'h0 || level != 32'h0) bad++;
      end
    end
    check("bounce_rejected", bad, 0);
    raw = 4'hE;
    wait_pulse(1'b0, k, n, pv, lv);
    check("bounce_then_hold_latency", {31'h0, (k >= 1 && k <= 14)}, 32'h1);
    check("bounce_then_hold_value", {28'h0, pv}, 32'h1);
    check("bounce_then_hold_level", lv, 32'h1);
    raw = 4'hF;
    wait_pulse(1'b1, k, n, pv, lv);
    check("bounce_release_value", {28'h0, pv}, 32'h1);
    check("bounce_release_level", level, 32'h0);

    // Simultaneous press of bits 1 and 3
    raw = 4'h5;
    wait_pulse(1'b0, k, n, pv, lv);
    check("simul_press_value", {28'h0, pv}, 32'hA);
    check("simul_press_single", n, 1);
    check("simul_level", lv, 32'h0000000A);
    raw = 4'hF;
    wait_pulse(1'b1, k, n, pv, lv);
    check("simul_release_value", {28'h0, pv}, 32'hA);
    check("simul_release_level", level, 32'h0);

    // Reset while bit2 is two ticks into qualification (bit0 already accepted)
    raw = 4'hE;
    wait_pulse(1'b0, k, n, pv, lv);
    check("pre_reset_level", level, 32'h1);
    raw = 4'hA;
    cyc(10);
    check("pre_reset_bit2_pending", level, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_level", level, 32'h0);
    check("async_rst_press", {28'h0, press}, 32'h0);
    check("async_rst_release", {28'h0, rel}, 32'h0);
    check("async_rst_tick", {31'h0, tick}, 32'h0);
    @(posedge clk);
    #1;
    cyc(2);
    rst_n = 1'b1;
    check("post_rst_level", level, 32'h0);
    wait_pulse(1'b0, k, n, pv, lv);
    check("post_rst_full_latency", k, 12);
    check("post_rst_press_value", {28'h0, pv}, 32'h5);
    check("post_rst_press_single", n, 1);
    check("post_rst_level_after", lv, 32'h5);
    raw = 4'hF;
    wait_pulse(1'b1, k, n, pv, lv);
    check("post_rst_release_value", {28'h0, pv}, 32'h5);
    check("post_rst_release_level", level, 32'h0);

`ifdef INPUT_CONDITIONER_TOGGLE_EN
    // Toggle latch on bit3
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    check("toggle_reset", {28'h0, toggle}, 32'h0);
    raw = 4'h7;
    wait_pulse(1'b0, k, n, pv, lv);
    check("toggle_press1_pulse", {28'h0, pv}, 32'h8);
    check("toggle_after_press1", {28'h0, toggle}, 32'h8);
    raw = 4'hF;
    wait_pulse(1'b1, k, n, pv, lv);
    check("toggle_after_release1", {28'h0, toggle}, 32'h8);
    raw = 4'h7;
    wait_pulse(1'b0, k, n, pv, lv);
    check("toggle_after_press2", {28'h0, toggle}, 32'h0);
    raw = 4'hF;
    wait_pulse(1'b1, k, n, pv, lv);
    check("toggle_after_release2", {28'h0, toggle}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
